// File: rtl/datamem_arb_pkg.sv
// Shared types for the data-memory arbiter.
//   arb_state_t : ARB (free arbitration), LOCKED_0 / LOCKED_1 (grant pinned to one port)
//   port_idx_t  : 1-bit requester index (0 = CPU load/store unit, 1 = loader/debug master)
//   NUM_PORTS   : number of requesters sharing the memory
//   port_onehot : converts a port index into a one-hot grant/response vector
package datamem_arb_pkg;

  localparam int NUM_PORTS = 2;

  typedef enum logic [1:0] {
    ARB      = 2'd0,
    LOCKED_0 = 2'd1,
    LOCKED_1 = 2'd2
  } arb_state_t;

  typedef logic port_idx_t;

  function automatic logic [NUM_PORTS-1:0] port_onehot(input port_idx_t p);
    return p ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-way combinational grant selector.
// Ports:
//   valid      in  2  per-port request valid
//   ptr        in  1  preferred port when round-robin
//   fixed_mode in  1  1: port 0 always preferred, ptr ignored
//   grant      out 2  one-hot grant, zero when nothing is valid
module rr_arb2
  import datamem_arb_pkg::*;
(
  input  logic [NUM_PORTS-1:0] valid,
  input  port_idx_t            ptr,
  input  logic                 fixed_mode,
  output logic [NUM_PORTS-1:0] grant
);

  port_idx_t pref;

  // Fixed priority is just round-robin with the preference pinned to port 0.
  always_comb begin
    pref  = fixed_mode ? 1'b0 : ptr;
    grant = '0;
    if (valid[pref]) begin
      grant = port_onehot(pref);
    end else if (valid[~pref]) begin
      grant = port_onehot(~pref);
    end
  end

endmodule

// File: rtl/datamem_arbiter.sv
// Arbiter sharing one single-port, synchronous-read data memory between the
// CPU load/store unit (port 0) and the loader/debug master (port 1).
// At most one access per cycle; read data returns to the issuing port one
// cycle after the handshake. A lock keeps the grant on one port for atomic
// read-modify-write sequences.
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   req_valid/ready/we/lock    per-port handshake and request attributes
//   req_addr0/1, req_wdata0/1  per-port address and write data
//   resp_valid, resp_rdata     one-cycle read response pulse and shared data
//   mem_address, mem_write_data, mem_write_enable, mem_read_data  memory side
module datamem_arbiter
  import datamem_arb_pkg::*;
#(
  parameter int DATA_WIDTH     = 32,
  parameter int ADDRESS_WIDTH  = 16,
  parameter int FIXED_PRIORITY = 0
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NUM_PORTS-1:0]     req_valid,
  output logic [NUM_PORTS-1:0]     req_ready,
  input  logic [NUM_PORTS-1:0]     req_we,
  input  logic [NUM_PORTS-1:0]     req_lock,
  input  logic [ADDRESS_WIDTH-1:0] req_addr0,
  input  logic [ADDRESS_WIDTH-1:0] req_addr1,
  input  logic [DATA_WIDTH-1:0]    req_wdata0,
  input  logic [DATA_WIDTH-1:0]    req_wdata1,
  output logic [NUM_PORTS-1:0]     resp_valid,
  output logic [DATA_WIDTH-1:0]    resp_rdata,
  output logic [ADDRESS_WIDTH-1:0] mem_address,
  output logic [DATA_WIDTH-1:0]    mem_write_data,
  output logic                     mem_write_enable,
  input  logic [DATA_WIDTH-1:0]    mem_read_data
);

  arb_state_t           state;
  port_idx_t            rr_ptr;
  logic                 pend_vld;
  port_idx_t            pend_port;
  logic [NUM_PORTS-1:0] arb_grant;
  logic                 xfer;
  port_idx_t            gnt_port;

  rr_arb2 u_rr_arb2 (
    .valid      (req_valid),
    .ptr        (rr_ptr),
    .fixed_mode (FIXED_PRIORITY != 0),
    .grant      (arb_grant)
  );

  // While locked, only the owner can be granted, even if it is idle.
  // Nothing is granted while reset is asserted.
  always_comb begin
    req_ready = '0;
    if (rst_n) begin
      case (state)
        ARB:      req_ready = arb_grant;
        LOCKED_0: req_ready = {1'b0, req_valid[0]};
        LOCKED_1: req_ready = {req_valid[1], 1'b0};
        default:  req_ready = '0;
      endcase
    end
  end

  // The ready vector is one-hot or zero, so bit 1 alone identifies the port.
  // When idle this selects port 0's address, which only costs a harmless read.
  assign xfer             = |req_ready;
  assign gnt_port         = req_ready[1];
  assign mem_address      = gnt_port ? req_addr1 : req_addr0;
  assign mem_write_data   = gnt_port ? req_wdata1 : req_wdata0;
  assign mem_write_enable = xfer & req_we[gnt_port];

  // Memory registers its read data, so it lines up with the pending-read flag.
  assign resp_valid = pend_vld ? port_onehot(pend_port) : '0;
  assign resp_rdata = mem_read_data;

  // Lock FSM, round-robin pointer and pending-read tracking.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ARB;
      rr_ptr    <= 1'b0;
      pend_vld  <= 1'b0;
      pend_port <= 1'b0;
    end else begin
      pend_vld  <= xfer & ~req_we[gnt_port];
      pend_port <= gnt_port;
      if (xfer) begin
        case (state)
          ARB: begin
            rr_ptr <= ~gnt_port;
            if (req_lock[gnt_port]) begin
              state <= gnt_port ? LOCKED_1 : LOCKED_0;
            end
          end
          LOCKED_0, LOCKED_1: begin
            if (!req_lock[gnt_port]) begin
              state  <= ARB;
              rr_ptr <= ~gnt_port;
            end
          end
          default: state <= ARB;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_datamem_arbiter.sv
// Bench for datamem_arbiter: a round-robin instance driven by a vector table,
// a reset-while-locked sequence and random traffic against a behavioural
// model, plus a fixed-priority instance driven by a short hand sequence.
// Each instance talks to its own synchronous-read memory (read before write).
module tb_datamem_arbiter;

  localparam int DW = 32;
  localparam int AW = 8;

  logic clk = 1'b0;
  logic rst_n;
  logic clear_mem;

  always #5 clk = ~clk;

  // Round-robin instance
  logic [1:0]    valid, we, lock, ready, resp_valid;
  logic [AW-1:0] addr0, addr1, mem_addr;
  logic [DW-1:0] wdata0, wdata1, resp_rdata, mem_wdata, mem_rdata;
  logic          mem_we;

  // Fixed-priority instance
  logic [1:0]    f_valid, f_we, f_lock, f_ready, f_resp_valid;
  logic [AW-1:0] f_addr0, f_addr1, f_mem_addr;
  logic [DW-1:0] f_wdata0, f_wdata1, f_resp_rdata, f_mem_wdata, f_mem_rdata;
  logic          f_mem_we;

  datamem_arbiter #(.DATA_WIDTH(DW), .ADDRESS_WIDTH(AW), .FIXED_PRIORITY(0)) u_dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(valid), .req_ready(ready), .req_we(we), .req_lock(lock),
    .req_addr0(addr0), .req_addr1(addr1), .req_wdata0(wdata0), .req_wdata1(wdata1),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata),
    .mem_address(mem_addr), .mem_write_data(mem_wdata),
    .mem_write_enable(mem_we), .mem_read_data(mem_rdata)
  );

  datamem_arbiter #(.DATA_WIDTH(DW), .ADDRESS_WIDTH(AW), .FIXED_PRIORITY(1)) u_dut_fixed (
    .clk(clk), .rst_n(rst_n),
    .req_valid(f_valid), .req_ready(f_ready), .req_we(f_we), .req_lock(f_lock),
    .req_addr0(f_addr0), .req_addr1(f_addr1), .req_wdata0(f_wdata0), .req_wdata1(f_wdata1),
    .resp_valid(f_resp_valid), .resp_rdata(f_resp_rdata),
    .mem_address(f_mem_addr), .mem_write_data(f_mem_wdata),
    .mem_write_enable(f_mem_we), .mem_read_data(f_mem_rdata)
  );

  // Data memories: registered read of the old contents, write in the same edge.
  logic [DW-1:0] mem_rr [256];
  logic [DW-1:0] mem_fx [256];

  always @(posedge clk) begin
    if (clear_mem) begin
      for (int i = 0; i < 256; i++) begin
        mem_rr[i] <= '0;
        mem_fx[i] <= '0;
      end
      mem_rdata   <= '0;
      f_mem_rdata <= '0;
    end else begin
      if (mem_we) mem_rr[mem_addr] <= mem_wdata;
      mem_rdata <= mem_rr[mem_addr];
      if (f_mem_we) mem_fx[f_mem_addr] <= f_mem_wdata;
      f_mem_rdata <= mem_fx[f_mem_addr];
    end
  end

  int tests_run    = 0;
  int tests_failed = 0;

  // Behavioural model of the round-robin instance.
  int            m_owner;
  int            m_pref;
  int            last_grant;
  logic [DW-1:0] m_mem [256];
  logic          exp_rv;
  int            exp_rp;
  logic [DW-1:0] exp_rd;

  typedef struct {
    logic [1:0]    valid, we, lock;
    logic [AW-1:0] addr0, addr1;
    logic [DW-1:0] wdata0, wdata1;
    logic [1:0]    exp_ready, exp_resp;
    logic [DW-1:0] exp_rdata;
  } vec_t;

  vec_t vecs[19];

  function automatic vec_t mk(input logic [1:0] v, input logic [1:0] w, input logic [1:0] l,
                              input logic [AW-1:0] a0, input logic [AW-1:0] a1,
                              input logic [DW-1:0] d0, input logic [DW-1:0] d1,
                              input logic [1:0] er, input logic [1:0] ep, input logic [DW-1:0] ed);
    vec_t r;
    r.valid = v; r.we = w; r.lock = l; r.addr0 = a0; r.addr1 = a1;
    r.wdata0 = d0; r.wdata1 = d1; r.exp_ready = er; r.exp_resp = ep; r.exp_rdata = ed;
    return r;
  endfunction

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    m_owner    = -1;
    m_pref     = 0;
    last_grant = -1;
    exp_rv     = 1'b0;
    exp_rp     = 0;
    exp_rd     = '0;
  endtask

  task automatic apply_stimulus(input vec_t v);
    valid = v.valid; we = v.we; lock = v.lock;
    addr0 = v.addr0; addr1 = v.addr1; wdata0 = v.wdata0; wdata1 = v.wdata1;
  endtask

  // One clock of the round-robin instance: check against the model (and the
  // table expectation when given) at the falling edge, then advance the model.
  task automatic step(input logic has_exp, input logic [1:0] e_ready, input logic [1:0] e_resp,
                      input logic [DW-1:0] e_rdata, input string tag);
    int            g;
    logic [1:0]    m_ready, m_resp;
    logic          m_we;
    logic [AW-1:0] g_addr;
    logic [DW-1:0] g_wdata;
    @(negedge clk);
    g = -1;
    if (m_owner >= 0) begin
      if (valid[m_owner]) g = m_owner;
    end else if (valid[m_pref]) begin
      g = m_pref;
    end else if (valid[1 - m_pref]) begin
      g = 1 - m_pref;
    end
    m_ready = (g < 0) ? 2'b00 : ((g == 1) ? 2'b10 : 2'b01);
    m_we    = (g >= 0) ? we[g] : 1'b0;
    g_addr  = (g == 1) ? addr1 : addr0;
    g_wdata = (g == 1) ? wdata1 : wdata0;
    m_resp  = exp_rv ? ((exp_rp == 1) ? 2'b10 : 2'b01) : 2'b00;
    check_output({tag, " ready"}, ready, m_ready);
    check_output({tag, " mem_we"}, mem_we, m_we);
    check_output({tag, " mem_addr"}, mem_addr, g_addr);
    if (m_we) check_output({tag, " mem_wdata"}, mem_wdata, g_wdata);
    check_output({tag, " resp_valid"}, resp_valid, m_resp);
    if (exp_rv) check_output({tag, " resp_rdata"}, resp_rdata, exp_rd);
    if (has_exp) begin
      check_output({tag, " table ready"}, ready, e_ready);
      check_output({tag, " table resp_valid"}, resp_valid, e_resp);
      if (e_resp != 2'b00) check_output({tag, " table rdata"}, resp_rdata, e_rdata);
    end
    if (g >= 0) begin
      exp_rv = !we[g];
      exp_rp = g;
      exp_rd = m_mem[g_addr];
      if (we[g]) m_mem[g_addr] = g_wdata;
      if (m_owner < 0) begin
        m_pref = 1 - g;
        if (lock[g]) m_owner = g;
      end else if (!lock[g]) begin
        m_owner = -1;
        m_pref  = 1 - g;
      end
    end else begin
      exp_rv = 1'b0;
    end
    last_grant = g;
    @(posedge clk);
    #1;
  endtask

  task automatic fixed_cycle(input logic [1:0] e_ready, input logic [1:0] e_resp,
                             input logic [DW-1:0] e_rdata, input string tag);
    @(negedge clk);
    check_output({tag, " ready"}, f_ready, e_ready);
    check_output({tag, " resp_valid"}, f_resp_valid, e_resp);
    if (e_resp != 2'b00) check_output({tag, " rdata"}, f_resp_rdata, e_rdata);
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [AW-1:0] a;
    logic [DW-1:0] w;

    // Write/read, alternating stream, locked read-modify-write of 0x20.
    vecs[0]  = mk(2'b11, 2'b01, 2'b00, 8'h10, 8'h30, 32'hDEADBEEF, 32'h0, 2'b01, 2'b00, 32'h0);
    vecs[1]  = mk(2'b10, 2'b00, 2'b00, 8'h10, 8'h30, 32'h0, 32'h0, 2'b10, 2'b00, 32'h0);
    vecs[2]  = mk(2'b01, 2'b00, 2'b00, 8'h10, 8'h30, 32'h0, 32'h0, 2'b01, 2'b10, 32'h0);
    vecs[3]  = mk(2'b10, 2'b10, 2'b00, 8'h10, 8'h30, 32'h0, 32'h11111111, 2'b10, 2'b01, 32'hDEADBEEF);
    vecs[4]  = mk(2'b11, 2'b00, 2'b00, 8'h10, 8'h30, 32'h0, 32'h0, 2'b01, 2'b00, 32'h0);
    for (int i = 5; i < 12; i++) begin
      if (i % 2 == 1)
        vecs[i] = mk(2'b11, 2'b00, 2'b00, 8'h10, 8'h30, 32'h0, 32'h0, 2'b10, 2'b01, 32'hDEADBEEF);
      else
        vecs[i] = mk(2'b11, 2'b00, 2'b00, 8'h10, 8'h30, 32'h0, 32'h0, 2'b01, 2'b10, 32'h11111111);
    end
    vecs[12] = mk(2'b01, 2'b01, 2'b00, 8'h20, 8'h30, 32'h41, 32'h0, 2'b01, 2'b10, 32'h11111111);
    vecs[13] = mk(2'b11, 2'b00, 2'b10, 8'h10, 8'h20, 32'h0, 32'h0, 2'b10, 2'b00, 32'h0);
    vecs[14] = mk(2'b01, 2'b00, 2'b00, 8'h10, 8'h20, 32'h0, 32'h0, 2'b00, 2'b10, 32'h41);
    vecs[15] = mk(2'b11, 2'b10, 2'b00, 8'h10, 8'h20, 32'h0, 32'h42, 2'b10, 2'b00, 32'h0);
    vecs[16] = mk(2'b01, 2'b00, 2'b00, 8'h10, 8'h20, 32'h0, 32'h0, 2'b01, 2'b00, 32'h0);
    vecs[17] = mk(2'b10, 2'b00, 2'b00, 8'h10, 8'h20, 32'h0, 32'h0, 2'b10, 2'b01, 32'hDEADBEEF);
    vecs[18] = mk(2'b00, 2'b00, 2'b00, 8'h10, 8'h20, 32'h0, 32'h0, 2'b00, 2'b10, 32'h42);

    for (int i = 0; i < 256; i++) m_mem[i] = '0;
    model_reset();

    // Reset with both ports requesting: nothing granted, no response.
    rst_n = 1'b0; clear_mem = 1'b1;
    valid = 2'b11; we = 2'b00; lock = 2'b00; addr0 = '0; addr1 = '0; wdata0 = '0; wdata1 = '0;
    f_valid = 2'b11; f_we = 2'b00; f_lock = 2'b00; f_addr0 = '0; f_addr1 = '0;
    f_wdata0 = '0; f_wdata1 = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_output("reset ready", ready, 2'b00);
    check_output("reset resp_valid", resp_valid, 2'b00);
    check_output("reset mem_we", mem_we, 1'b0);
    check_output("reset fixed ready", f_ready, 2'b00);
    @(posedge clk);
    #1;
    rst_n = 1'b1; clear_mem = 1'b0; f_valid = 2'b00;

    for (int i = 0; i < 19; i++) begin
      apply_stimulus(vecs[i]);
      step(1'b1, vecs[i].exp_ready, vecs[i].exp_resp, vecs[i].exp_rdata, $sformatf("vec%0d", i));
    end

    // Fixed priority: port 1 waits while port 0 keeps requesting.
    f_valid = 2'b01; f_we = 2'b01; f_addr0 = 8'h01; f_wdata0 = 32'hA5A5A5A5;
    fixed_cycle(2'b01, 2'b00, 32'h0, "fixed write");
    f_valid = 2'b11; f_we = 2'b00; f_addr0 = 8'h01; f_addr1 = 8'h02;
    fixed_cycle(2'b01, 2'b00, 32'h0, "fixed both0");
    for (int i = 1; i < 4; i++)
      fixed_cycle(2'b01, 2'b01, 32'hA5A5A5A5, $sformatf("fixed both%0d", i));
    f_valid = 2'b10;
    fixed_cycle(2'b10, 2'b01, 32'hA5A5A5A5, "fixed port1 turn");
    f_valid = 2'b00;
    fixed_cycle(2'b00, 2'b10, 32'h0, "fixed drain");

    // Reset while port 1 holds a lock and a read response is in flight.
    valid = 2'b10; we = 2'b00; lock = 2'b10; addr1 = 8'h20;
    step(1'b1, 2'b10, 2'b00, 32'h0, "lock before reset");
    rst_n = 1'b0;
    valid = 2'b11; lock = 2'b00; addr0 = 8'h10; addr1 = 8'h20;
    @(negedge clk);
    check_output("mid-read reset ready", ready, 2'b00);
    check_output("mid-read reset resp_valid", resp_valid, 2'b00);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    model_reset();
    step(1'b1, 2'b01, 2'b00, 32'h0, "after reset");

    // Random traffic; a port that was not granted keeps its request stable.
    for (int c = 0; c < 400; c++) begin
      for (int p = 0; p < 2; p++) begin
        if (!(valid[p] && last_grant != p)) begin
          valid[p] = ($urandom_range(3) != 0);
          we[p]    = 1'($urandom_range(1));
          lock[p]  = ($urandom_range(3) == 0);
          a        = AW'($urandom_range(15));
          w        = $urandom;
          if (p == 0) begin
            addr0 = a; wdata0 = w;
          end else begin
            addr1 = a; wdata1 = w;
          end
        end
      end
      step(1'b0, 2'b00, 2'b00, 32'h0, "rand");
    end
    valid = 2'b00;
    step(1'b0, 2'b00, 2'b00, 32'h0, "final");

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
